// File: rtl/stopwatch_digit_source.sv
// MM:SS stopwatch that feeds the four nibble inputs of the seven-segment
// display driver. Three button inputs are synchronised and edge-detected,
// a prescaler turns clk into a once-per-second tick, and a small control FSM
// decides whether the BCD count advances and whether the display shows the
// live count or a frozen lap snapshot.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | stopped at whatever count is held, prescaler held at 0
//   ST_RUN   | prescaler counting, live count shown
//   ST_PAUSE | prescaler and count frozen, live count shown
//   ST_LAP   | prescaler and count still advancing, snapshot shown

module stopwatch_digit_source #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start_btn,
    input  logic       lap_btn,
    input  logic       zero_btn,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       lap_active,
    output logic       rollover
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

    // Bit positions of the three buttons in the synchroniser vectors.
    localparam int unsigned B_START = 0;
    localparam int unsigned B_LAP   = 1;
    localparam int unsigned B_ZERO  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [2:0] btn_raw;
    logic [2:0] btn_meta;
    logic [2:0] btn_sync;
    logic [2:0] btn_prev;
    logic [2:0] btn_press;

    logic start_press;
    logic lap_press;
    logic zero_press;

    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_nxt;
    logic             counting;
    logic             tick;

    // Live count, one BCD nibble per display position.
    logic [3:0] cnt_d0_q, cnt_d1_q, cnt_d2_q, cnt_d3_q;
    logic [3:0] cnt_d0_nxt, cnt_d1_nxt, cnt_d2_nxt, cnt_d3_nxt;

    // Lap snapshot, loaded from the live count on lap entry.
    logic [3:0] snap_d0_q, snap_d1_q, snap_d2_q, snap_d3_q;
    logic [3:0] snap_d0_nxt, snap_d1_nxt, snap_d2_nxt, snap_d3_nxt;

    logic zero_act;
    logic snap_load;
    logic wrap;

    logic [3:0] digit0_q, digit1_q, digit2_q, digit3_q;
    logic       running_q;
    logic       lap_active_q;
    logic       rollover_q;

    assign btn_raw   = {zero_btn, lap_btn, start_btn};
    assign btn_press = btn_sync & ~btn_prev;

    assign start_press = btn_press[B_START];
    assign lap_press   = btn_press[B_LAP];
    assign zero_press  = btn_press[B_ZERO];

    // Two-flop synchroniser plus previous-value flop for edge detection.
    // Cleared on reset so a button held across release gives one press.
    always_ff @(posedge clk) begin
        if (!clr) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // Control FSM next state; start wins over lap, zero wins over start.
    always_comb begin
        state_nxt = state_q;
        zero_act  = 1'b0;
        snap_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lap_press) begin
                    state_nxt = ST_LAP;
                    snap_load = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lap_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (zero_press) begin
                    state_nxt = ST_IDLE;
                    zero_act  = 1'b1;
                end else if (start_press) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (presc_q == PRESC_LAST);

    // Prescaler: advances while counting, frozen in pause, zeroed when idle.
    always_comb begin
        presc_nxt = presc_q;
        if (zero_act || (state_q == ST_IDLE)) begin
            presc_nxt = '0;
        end else if (counting) begin
            if (tick) begin
                presc_nxt = '0;
            end else begin
                presc_nxt = presc_q + PRESC_ONE;
            end
        end
    end

    // Cascaded BCD count; >= compares keep any digit from escaping its range.
    always_comb begin
        cnt_d0_nxt = cnt_d0_q;
        cnt_d1_nxt = cnt_d1_q;
        cnt_d2_nxt = cnt_d2_q;
        cnt_d3_nxt = cnt_d3_q;
        wrap       = 1'b0;
        if (zero_act) begin
            cnt_d0_nxt = 4'd0;
            cnt_d1_nxt = 4'd0;
            cnt_d2_nxt = 4'd0;
            cnt_d3_nxt = 4'd0;
        end else if (tick) begin
            if (cnt_d0_q >= 4'd9) begin
                cnt_d0_nxt = 4'd0;
                if (cnt_d1_q >= 4'd5) begin
                    cnt_d1_nxt = 4'd0;
                    if (cnt_d2_q >= 4'd9) begin
                        cnt_d2_nxt = 4'd0;
                        if (cnt_d3_q >= 4'd5) begin
                            cnt_d3_nxt = 4'd0;
                            wrap       = 1'b1;
                        end else begin
                            cnt_d3_nxt = cnt_d3_q + 4'd1;
                        end
                    end else begin
                        cnt_d2_nxt = cnt_d2_q + 4'd1;
                    end
                end else begin
                    cnt_d1_nxt = cnt_d1_q + 4'd1;
                end
            end else begin
                cnt_d0_nxt = cnt_d0_q + 4'd1;
            end
        end
    end

    // Snapshot captures the pre-increment count on the lap-entry edge.
    always_comb begin
        snap_d0_nxt = snap_d0_q;
        snap_d1_nxt = snap_d1_q;
        snap_d2_nxt = snap_d2_q;
        snap_d3_nxt = snap_d3_q;
        if (snap_load) begin
            snap_d0_nxt = cnt_d0_q;
            snap_d1_nxt = cnt_d1_q;
            snap_d2_nxt = cnt_d2_q;
            snap_d3_nxt = cnt_d3_q;
        end
    end

    // Datapath registers: prescaler, live count and snapshot.
    always_ff @(posedge clk) begin
        if (!clr) begin
            presc_q   <= '0;
            cnt_d0_q  <= 4'd0;
            cnt_d1_q  <= 4'd0;
            cnt_d2_q  <= 4'd0;
            cnt_d3_q  <= 4'd0;
            snap_d0_q <= 4'd0;
            snap_d1_q <= 4'd0;
            snap_d2_q <= 4'd0;
            snap_d3_q <= 4'd0;
        end else begin
            presc_q   <= presc_nxt;
            cnt_d0_q  <= cnt_d0_nxt;
            cnt_d1_q  <= cnt_d1_nxt;
            cnt_d2_q  <= cnt_d2_nxt;
            cnt_d3_q  <= cnt_d3_nxt;
            snap_d0_q <= snap_d0_nxt;
            snap_d1_q <= snap_d1_nxt;
            snap_d2_q <= snap_d2_nxt;
            snap_d3_q <= snap_d3_nxt;
        end
    end

    // Output registers are fed from next-state values so that digits and
    // status flags change on the same edge as the count and state.
    always_ff @(posedge clk) begin
        if (!clr) begin
            digit0_q     <= 4'd0;
            digit1_q     <= 4'd0;
            digit2_q     <= 4'd0;
            digit3_q     <= 4'd0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            rollover_q   <= 1'b0;
        end else begin
            if (state_nxt == ST_LAP) begin
                digit0_q <= snap_d0_nxt;
                digit1_q <= snap_d1_nxt;
                digit2_q <= snap_d2_nxt;
                digit3_q <= snap_d3_nxt;
            end else begin
                digit0_q <= cnt_d0_nxt;
                digit1_q <= cnt_d1_nxt;
                digit2_q <= cnt_d2_nxt;
                digit3_q <= cnt_d3_nxt;
            end
            running_q    <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
            lap_active_q <= (state_nxt == ST_LAP);
            rollover_q   <= wrap;
        end
    end

    assign digit0     = digit0_q;
    assign digit1     = digit1_q;
    assign digit2     = digit2_q;
    assign digit3     = digit3_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_digit_source.sv
module tb_stopwatch_digit_source;

    typedef struct packed {
        logic [15:0] bcd;   // {d3, d2, d1, d0}
        logic        run;
        logic        lap;
        logic        roll;
    } obs_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start_btn = 1'b0;
    logic       lap_btn = 1'b0;
    logic       zero_btn = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       running, lap_active, rollover;

    int n_assert = 0;
    int n_fail   = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    stopwatch_digit_source #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .start_btn (start_btn),
        .lap_btn   (lap_btn),
        .zero_btn  (zero_btn),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .running   (running),
        .lap_active(lap_active),
        .rollover  (rollover)
    );

    function automatic obs_t mk(input logic [3:0] d3, input logic [3:0] d2,
                                input logic [3:0] d1, input logic [3:0] d0,
                                input logic r, input logic l, input logic o);
        obs_t v;
        v.bcd  = {d3, d2, d1, d0};
        v.run  = r;
        v.lap  = l;
        v.roll = o;
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard push: the expectation is recorded when stimulus is applied.
    task automatic expect_out(input string tag, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Scoreboard pop: compare the DUT outputs against the oldest expectation.
    task automatic check_out();
        obs_t  o;
        obs_t  e;
        string t;
        o = {digit3, digit2, digit1, digit0, running, lap_active, rollover};
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: got %h expected an entry", o);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s: got digits %h run %b lap %b roll %b, expected digits %h run %b lap %b roll %b",
                       t, o.bcd, o.run, o.lap, o.roll, e.bcd, e.run, e.lap, e.roll);
            end
        end
    endtask

    task automatic see(input string tag, input obs_t e, input int n);
        expect_out(tag, e);
        cyc(n);
        check_out();
    endtask

    // One-cycle button pulse; returns on the edge the FSM reacts.
    task automatic press(input logic s, input logic l, input logic z);
        start_btn = s;
        lap_btn   = l;
        zero_btn  = z;
        cyc(1);
        start_btn = 1'b0;
        lap_btn   = 1'b0;
        zero_btn  = 1'b0;
        cyc(2);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        cyc(1);
        clr = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1);
        // reset and first start
        clr = 1'b0;
        cyc(3);
        see("reset", mk(0, 0, 0, 0, 0, 0, 0), 0);
        clr = 1'b1;
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
        see("t1_pre_run", mk(0, 0, 0, 0, 0, 0, 0), 1);
        see("t1_run", mk(0, 0, 0, 0, 1, 0, 0), 1);
        see("t1_before_tick", mk(0, 0, 0, 0, 1, 0, 0), 3);
        see("t1_tick1", mk(0, 0, 0, 1, 1, 0, 0), 1);
        see("t1_tick2", mk(0, 0, 0, 2, 1, 0, 0), 4);

        // wrap at 59:59
        do_reset();
        press(1, 0, 0);
        cyc(4 * 3599);
        see("t2_5959", mk(5, 9, 5, 9, 1, 0, 0), 0);
        see("t2_wrap", mk(0, 0, 0, 0, 1, 0, 1), 4);
        see("t2_roll_off", mk(0, 0, 0, 0, 1, 0, 0), 1);
        see("t2_after", mk(0, 0, 0, 1, 1, 0, 0), 3);

        // lap freeze
        do_reset();
        press(1, 0, 0);
        cyc(28);
        see("t3_007", mk(0, 0, 0, 7, 1, 0, 0), 0);
        press(0, 1, 0);
        see("t3_lap", mk(0, 0, 0, 7, 1, 1, 0), 0);
        see("t3_hold", mk(0, 0, 0, 7, 1, 1, 0), 17);
        press(0, 1, 0);
        see("t3_unlap", mk(0, 0, 1, 2, 1, 0, 0), 0);

        // pause, resume, zero
        do_reset();
        press(1, 0, 0);
        cyc(8 + 3);
        press(1, 0, 0);
        see("t4_pause", mk(0, 0, 0, 3, 0, 0, 0), 0);
        see("t4_hold", mk(0, 0, 0, 3, 0, 0, 0), 20);
        press(1, 0, 0);
        see("t4_resume", mk(0, 0, 0, 3, 1, 0, 0), 0);
        see("t4_pre_tick", mk(0, 0, 0, 3, 1, 0, 0), 1);
        see("t4_tick", mk(0, 0, 0, 4, 1, 0, 0), 1);
        press(1, 0, 0);
        see("t4_pause2", mk(0, 0, 0, 4, 0, 0, 0), 0);
        press(0, 0, 1);
        see("t4_zero", mk(0, 0, 0, 0, 0, 0, 0), 0);
        see("t4_idle_hold", mk(0, 0, 0, 0, 0, 0, 0), 8);
        press(1, 0, 0);
        cyc(4);
        see("t4_run1", mk(0, 0, 0, 1, 1, 0, 0), 0);
        press(0, 0, 1);
        see("t4_zero_in_run", mk(0, 0, 0, 1, 1, 0, 0), 0);
        see("t4_zero_in_run_tick", mk(0, 0, 0, 2, 1, 0, 0), 1);

        // simultaneous presses
        press(1, 1, 0);
        see("t5_start_lap", mk(0, 0, 0, 2, 0, 0, 0), 0);
        press(1, 0, 1);
        see("t5_start_zero", mk(0, 0, 0, 0, 0, 0, 0), 0);
        see("t5_idle_hold", mk(0, 0, 0, 0, 0, 0, 0), 10);

        // mid-run reset with start held across it
        press(1, 0, 0);
        cyc(100);
        see("t6_025", mk(0, 0, 2, 5, 1, 0, 0), 0);
        press(0, 1, 0);
        see("t6_lap", mk(0, 0, 2, 5, 1, 1, 0), 0);
        clr = 1'b0;
        start_btn = 1'b1;
        cyc(1);
        see("t6_reset", mk(0, 0, 0, 0, 0, 0, 0), 0);
        clr = 1'b1;
        see("t6_sync", mk(0, 0, 0, 0, 0, 0, 0), 2);
        see("t6_run", mk(0, 0, 0, 0, 1, 0, 0), 1);
        see("t6_tick", mk(0, 0, 0, 1, 1, 0, 0), 4);
        see("t6_held", mk(0, 0, 0, 5, 1, 0, 0), 16);
        start_btn = 1'b0;
        see("t6_release", mk(0, 0, 0, 5, 1, 0, 0), 3);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
